branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Decode-stage counterpart to the dynamic branch predictor.
- Consumes the IF/ID-pipelined prediction (2-bit counter, predicted target, fetch PC) plus decoded branch fields and ALU flags.
- Resolves actual direction and target; drives BHT/BTB write enables and PC redirect back to the predictor/fetch.
- Squash FSM blocks double redirects; optional saturating branch statistics counters.

Parameters:
- ADDR_W, 16, PC/target width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  pipeline advance (0 = stall)
- is_branch  in  1  ID instruction is B or BR
- is_BR  in  1  1 = register-indirect BR, 0 = PC-relative B
- cond  in  3  branch condition code
- imm9  in  9  signed word offset for B
- rs_data  in  ADDR_W  register target for BR
- flags  in  3  {Z,V,N} from flag register
- IF_ID_PC_curr  in  ADDR_W  PC of instruction in ID
- IF_ID_prediction  in  2  predictor counter captured at fetch
- IF_ID_predicted_target  in  ADDR_W  BTB target captured at fetch
- actual_taken  out  1  resolved direction
- actual_target  out  ADDR_W  resolved target (0x0000 when not taken)
- wen_BHT  out  1  BHT update strobe
- wen_BTB  out  1  BTB update strobe
- update_PC  out  1  redirect fetch
- redirect_PC  out  ADDR_W  PC to load on redirect
- IF_ID_flush  out  1  squash instruction currently in IF
- branch_count, mispredict_count, taken_count  out  CNT_W each  statistics (see Optional Feature)

Behaviour:
- rst_n low (async): state = RESOLVE, counters = 0; every output forced 0 while rst_n low.
- Condition (cond): 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GTE Z=1|(Z=0&N=0); 101 LTE N=1|Z=1; 110 OVFL V=1; 111 always.
- Target:
  - B: IF_ID_PC_curr + 2 + (sign_ext(imm9) << 1), mod 2^ADDR_W (wraps, no saturation).
  - BR: rs_data.
- valid = is_branch & enable & (state == RESOLVE). All resolution outputs are combinational, same cycle, gated by valid.
- actual_taken = valid & cond_true.
- actual_target = actual_taken ? target : 0x0000.
- mispredicted = actual_taken != IF_ID_prediction[1].
- target_miscomputed = actual_taken & (IF_ID_predicted_target != target).
- wen_BHT = valid.
- wen_BTB = valid & actual_taken & target_miscomputed.
- update_PC = IF_ID_flush = valid & (mispredicted | target_miscomputed).
- redirect_PC = actual_taken ? target : IF_ID_PC_curr + 2; 0x0000 when update_PC = 0.
- FSM (registered):
  - RESOLVE -> SQUASH on update_PC.
  - SQUASH -> RESOLVE on the next cycle with enable = 1.
  - SQUASH holds while enable = 0.
  - In SQUASH, is_branch is ignored (wrong-path bubble): no wen, no redirect.
- enable = 0: all strobes 0, counters hold, state holds.
- Predicted taken with predicted target equal to the actual target: no redirect, wen_BHT only.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - On each valid cycle, branch_count += 1; taken_count += actual_taken; mispredict_count += update_PC.
  - Each counter saturates at 2^CNT_W - 1 (no wrap).
- Undefined: the three count outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset:
  - Drive rst_n = 0 asynchronously mid-cycle while is_branch = 1.
  - All outputs go to 0 immediately and state = RESOLVE.
  - After release, the first branch resolves normally.
- B, EQ, correctly predicted taken:
  - Inputs: Z = 1, imm9 = 0x004, IF_ID_PC_curr = 0x0010, prediction = 2'b11, predicted target = 0x001A.
  - Expect actual_taken = 1, actual_target = 0x001A, wen_BHT = 1, wen_BTB = 0, update_PC = 0.
- Predicted taken, actually not taken:
  - Inputs: NE with Z = 1, prediction = 2'b10, IF_ID_PC_curr = 0x0040.
  - Expect update_PC = 1, redirect_PC = 0x0042, actual_target = 0x0000, wen_BTB = 0.
  - Next cycle in SQUASH: is_branch = 1 produces no strobes.
- BR, miscomputed target:
  - Inputs: cond = 111, rs_data = 0x1234, prediction = 2'b11, predicted target = 0x1000.
  - Expect wen_BTB = 1, update_PC = 1, redirect_PC = 0x1234.
- Stall:
  - Mispredict, then enable = 0 for 3 cycles.
  - State stays SQUASH and strobes stay 0; returns to RESOLVE after the first enable = 1 cycle.
- Wrap and saturation:
  - B at IF_ID_PC_curr = 0xFFFE with imm9 = 0x001: target = 0x0002.
  - With BRANCH_STATS_EN and CNT_W = 4: 20 mispredicts leave mispredict_count = 15.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: computes actual direction/target, predictor update strobes and fetch redirect.
// Optional saturating statistics counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              is_branch,
    input  logic              is_BR,
    input  logic [2:0]        cond,
    input  logic [8:0]        imm9,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic [2:0]        flags,
    input  logic [ADDR_W-1:0] IF_ID_PC_curr,
    input  logic [1:0]        IF_ID_prediction,
    input  logic [ADDR_W-1:0] IF_ID_predicted_target,
    output logic              actual_taken,
    output logic [ADDR_W-1:0] actual_target,
    output logic              wen_BHT,
    output logic              wen_BTB,
    output logic              update_PC,
    output logic [ADDR_W-1:0] redirect_PC,
    output logic              IF_ID_flush,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic {
        RESOLVE = 1'b0,
        SQUASH  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    state_t state;
    state_t state_next;

    logic              flag_z;
    logic              flag_v;
    logic              flag_n;
    logic              cond_true;
    logic              valid;
    logic              mispredicted;
    logic              target_miscomputed;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] fall_through;
    logic [ADDR_W-1:0] target;

    assign {flag_z, flag_v, flag_n} = flags;

    // NOTE: every always_comb output gets a value before the case, so no path can infer a latch.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // Word offset: sign-extend imm9 and scale by 2; sum wraps modulo 2^ADDR_W.
    assign offset       = {{(ADDR_W-10){imm9[8]}}, imm9, 1'b0};
    assign fall_through = IF_ID_PC_curr + PC_STEP;
    assign target       = is_BR ? rs_data : fall_through + offset;

    // rst_n gates valid so every output reads 0 for as long as reset is held.
    assign valid              = rst_n & enable & is_branch & (state == RESOLVE);
    assign actual_taken       = valid & cond_true;
    assign mispredicted       = actual_taken != IF_ID_prediction[1];
    assign target_miscomputed = actual_taken & (IF_ID_predicted_target != target);

    assign actual_target = actual_taken ? target : '0;
    assign wen_BHT       = valid;
    assign wen_BTB       = valid & actual_taken & target_miscomputed;
    assign update_PC     = valid & (mispredicted | target_miscomputed);
    assign IF_ID_flush   = update_PC;
    assign redirect_PC   = !update_PC ? '0 : (actual_taken ? target : fall_through);

    // Only the direction bit of the 2-bit counter matters here.
    logic unused_prediction_lsb;
    assign unused_prediction_lsb = IF_ID_prediction[0];

    always_comb begin
        state_next = state;
        case (state)
            RESOLVE: if (update_PC) state_next = SQUASH;
            SQUASH:  if (enable)    state_next = RESOLVE;
            default:                state_next = RESOLVE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESOLVE;
        else        state <= state_next;
    end

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] branch_q;
    logic [CNT_W-1:0] mispredict_q;
    logic [CNT_W-1:0] taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_q     <= '0;
            mispredict_q <= '0;
            taken_q      <= '0;
        end else if (valid) begin
            if (branch_q != CNT_MAX)                   branch_q     <= branch_q + 1'b1;
            if (update_PC && mispredict_q != CNT_MAX)  mispredict_q <= mispredict_q + 1'b1;
            if (actual_taken && taken_q != CNT_MAX)    taken_q      <= taken_q + 1'b1;
        end
    end

    assign branch_count     = rst_n ? branch_q     : '0;
    assign mispredict_count = rst_n ? mispredict_q : '0;
    assign taken_count      = rst_n ? taken_q      : '0;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
    assign taken_count      = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, a behavioural model compared every cycle,
// and literal expectations; statistics expectations follow BRANCH_STATS_EN.
module tb_branch_resolve_unit;

    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              is_branch;
    logic              is_BR;
    logic [2:0]        cond;
    logic [8:0]        imm9;
    logic [ADDR_W-1:0] rs_data;
    logic [2:0]        flags;
    logic [ADDR_W-1:0] IF_ID_PC_curr;
    logic [1:0]        IF_ID_prediction;
    logic [ADDR_W-1:0] IF_ID_predicted_target;
    logic              actual_taken;
    logic [ADDR_W-1:0] actual_target;
    logic              wen_BHT;
    logic              wen_BTB;
    logic              update_PC;
    logic [ADDR_W-1:0] redirect_PC;
    logic              IF_ID_flush;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;
    logic [CNT_W-1:0]  taken_count;

    int checks = 0;
    int passes = 0;

    branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .enable                 (en),
        .is_branch              (is_branch),
        .is_BR                  (is_BR),
        .cond                   (cond),
        .imm9                   (imm9),
        .rs_data                (rs_data),
        .flags                  (flags),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .IF_ID_prediction       (IF_ID_prediction),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .actual_taken           (actual_taken),
        .actual_target          (actual_target),
        .wen_BHT                (wen_BHT),
        .wen_BTB                (wen_BTB),
        .update_PC              (update_PC),
        .redirect_PC            (redirect_PC),
        .IF_ID_flush            (IF_ID_flush),
        .branch_count           (branch_count),
        .mispredict_count       (mispredict_count),
        .taken_count            (taken_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    typedef struct {
        logic              taken;
        logic [ADDR_W-1:0] tgt;
        logic              bht;
        logic              btb;
        logic              upd;
        logic [ADDR_W-1:0] rpc;
    } exp_t;

    function automatic bit cond_holds(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Expected outputs from the current inputs, given whether the model is in the wrong-path bubble.
    function automatic exp_t model(input bit squashing);
        exp_t              e;
        bit                live, wrong_dir, wrong_tgt;
        int                off, sum;
        logic [ADDR_W-1:0] tgt;
        live = is_branch && en && !squashing;
        if (is_BR) tgt = rs_data;
        else begin
            off = imm9[8] ? int'(imm9) - 512 : int'(imm9);
            sum = int'(IF_ID_PC_curr) + 2 + 2 * off;
            tgt = ADDR_W'(sum % 65536 + (sum < 0 ? 65536 : 0));
        end
        e.taken   = live && cond_holds(cond, flags);
        e.tgt     = e.taken ? tgt : '0;
        wrong_dir = e.taken != IF_ID_prediction[1];
        wrong_tgt = e.taken && (IF_ID_predicted_target != tgt);
        e.bht     = live;
        e.btb     = e.taken && wrong_tgt;
        e.upd     = live && (wrong_dir || wrong_tgt);
        e.rpc     = !e.upd ? '0 : (e.taken ? tgt : IF_ID_PC_curr + 16'd2);
        return e;
    endfunction

    bit m_squash;
    int m_branches, m_mispredicts, m_takens;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_squash      <= 1'b0;
            m_branches    <= 0;
            m_mispredicts <= 0;
            m_takens      <= 0;
        end else begin
            if (m_squash) m_squash <= !en;
            else          m_squash <= model(1'b0).upd;
            if (model(m_squash).bht) begin
                m_branches    <= (m_branches < CNT_MAX) ? m_branches + 1 : CNT_MAX;
                if (model(m_squash).upd)
                    m_mispredicts <= (m_mispredicts < CNT_MAX) ? m_mispredicts + 1 : CNT_MAX;
                if (model(m_squash).taken)
                    m_takens      <= (m_takens < CNT_MAX) ? m_takens + 1 : CNT_MAX;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            e = model(m_squash);
            check("cmp actual_taken",  32'(actual_taken),  32'(e.taken));
            check("cmp actual_target", 32'(actual_target), 32'(e.tgt));
            check("cmp wen_BHT",       32'(wen_BHT),       32'(e.bht));
            check("cmp wen_BTB",       32'(wen_BTB),       32'(e.btb));
            check("cmp update_PC",     32'(update_PC),     32'(e.upd));
            check("cmp IF_ID_flush",   32'(IF_ID_flush),   32'(e.upd));
            check("cmp redirect_PC",   32'(redirect_PC),   32'(e.rpc));
`ifdef BRANCH_STATS_EN
            check("cmp branch_count",     32'(branch_count),     32'(m_branches));
            check("cmp mispredict_count", 32'(mispredict_count), 32'(m_mispredicts));
            check("cmp taken_count",      32'(taken_count),      32'(m_takens));
`else
            check("cmp branch_count",     32'(branch_count),     32'd0);
            check("cmp mispredict_count", 32'(mispredict_count), 32'd0);
            check("cmp taken_count",      32'(taken_count),      32'd0);
`endif
        end
    end

    task automatic drive(input logic br, input logic [2:0] c, input logic [8:0] imm,
                         input logic [15:0] rs, input logic [2:0] f, input logic [15:0] pc,
                         input logic [1:0] pred, input logic [15:0] pt);
        @(posedge clk);
        #1;
        en = 1'b1; is_branch = 1'b1; is_BR = br; cond = c; imm9 = imm; rs_data = rs;
        flags = f; IF_ID_PC_curr = pc; IF_ID_prediction = pred; IF_ID_predicted_target = pt;
        #1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        en = 1'b1; is_branch = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; is_branch = 1'b0; is_BR = 1'b0; cond = '0; imm9 = '0;
        rs_data = '0; flags = '0; IF_ID_PC_curr = '0; IF_ID_prediction = '0; IF_ID_predicted_target = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Always-taken B predicted not taken, then reset asserted mid-cycle.
        drive(1'b0, 3'b111, 9'h000, 16'h0, 3'b000, 16'h0020, 2'b00, 16'h0000);
        check("pre-reset actual_taken", 32'(actual_taken), 32'd1);
        check("pre-reset redirect_PC",  32'(redirect_PC),  32'h22);
        #1 rst_n = 1'b0;
        #1;
        check("reset actual_taken",  32'(actual_taken),  32'd0);
        check("reset actual_target", 32'(actual_target), 32'd0);
        check("reset wen_BHT",       32'(wen_BHT),       32'd0);
        check("reset update_PC",     32'(update_PC),     32'd0);
        check("reset IF_ID_flush",   32'(IF_ID_flush),   32'd0);
        check("reset redirect_PC",   32'(redirect_PC),   32'd0);
        check("reset branch_count",  32'(branch_count),  32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post-reset wen_BHT",   32'(wen_BHT),   32'd1);
        check("post-reset update_PC", 32'(update_PC), 32'd1);
        idle();

        // B EQ correctly predicted taken.
        drive(1'b0, 3'b001, 9'h004, 16'h0, 3'b100, 16'h0010, 2'b11, 16'h001A);
        check("beq actual_taken",  32'(actual_taken),  32'd1);
        check("beq actual_target", 32'(actual_target), 32'h1A);
        check("beq wen_BHT",       32'(wen_BHT),       32'd1);
        check("beq wen_BTB",       32'(wen_BTB),       32'd0);
        check("beq update_PC",     32'(update_PC),     32'd0);

        // NE with Z=1 predicted taken: not taken, redirect to fall-through.
        drive(1'b0, 3'b000, 9'h004, 16'h0, 3'b100, 16'h0040, 2'b10, 16'h004A);
        check("bne update_PC",     32'(update_PC),     32'd1);
        check("bne redirect_PC",   32'(redirect_PC),   32'h42);
        check("bne actual_target", 32'(actual_target), 32'd0);
        check("bne wen_BTB",       32'(wen_BTB),       32'd0);
        drive(1'b0, 3'b111, 9'h004, 16'h0, 3'b000, 16'h0050, 2'b00, 16'h0000);
        check("squash wen_BHT",   32'(wen_BHT),   32'd0);
        check("squash update_PC", 32'(update_PC), 32'd0);

        // BR with stale BTB target.
        drive(1'b1, 3'b111, 9'h000, 16'h1234, 3'b000, 16'h0060, 2'b11, 16'h1000);
        check("br wen_BTB",     32'(wen_BTB),     32'd1);
        check("br update_PC",   32'(update_PC),   32'd1);
        check("br redirect_PC", 32'(redirect_PC), 32'h1234);

        // Stall three cycles in SQUASH, then one enabled bubble, then live again.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 en = 1'b0;
            #1;
            check("stall wen_BHT",   32'(wen_BHT),   32'd0);
            check("stall update_PC", 32'(update_PC), 32'd0);
        end
        @(posedge clk);
        #1 en = 1'b1;
        #1;
        check("stall-exit bubble wen_BHT", 32'(wen_BHT), 32'd0);
        @(posedge clk);
        #2;
        check("resolve again wen_BHT", 32'(wen_BHT), 32'd1);
        idle();

        // PC wrap and negative offset.
        drive(1'b0, 3'b111, 9'h001, 16'h0, 3'b000, 16'hFFFE, 2'b11, 16'h0002);
        check("wrap actual_target", 32'(actual_target), 32'h0002);
        check("wrap update_PC",     32'(update_PC),     32'd0);
        drive(1'b0, 3'b111, 9'h1FC, 16'h0, 3'b000, 16'h0100, 2'b11, 16'h00FA);
        check("neg actual_target", 32'(actual_target), 32'h00FA);
        check("neg update_PC",     32'(update_PC),     32'd0);

        // Every condition code against every flag combination.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                drive(1'b0, 3'(c), 9'h010, 16'h0, 3'(f), 16'h0200, 2'b10, 16'h0222);
                idle();
            end
        end

        // Twenty mispredicts to saturate the statistics.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 3'b111, 9'h000, 16'h0, 3'b000, 16'h0300, 2'b00, 16'h0302);
            idle();
        end
`ifdef BRANCH_STATS_EN
        check("sat mispredict_count", 32'(mispredict_count), 32'd15);
        check("sat branch_count",     32'(branch_count),     32'd15);
`else
        check("nostats mispredict_count", 32'(mispredict_count), 32'd0);
        check("nostats branch_count",     32'(branch_count),     32'd0);
`endif

        @(posedge clk);
        #6;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
